// File: rtl/bp_be_issue_queue_pkg.sv
// Shared types and RISC-V opcode constants for the BE issue queue and its predecoder.
// Used by both the default build and the BP_BE_ISSUE_BYPASS_EN build.
package bp_be_issue_queue_pkg;

    localparam logic [6:0] op_load     = 7'b0000011;
    localparam logic [6:0] op_load_fp  = 7'b0000111;
    localparam logic [6:0] op_misc_mem = 7'b0001111;
    localparam logic [6:0] op_imm      = 7'b0010011;
    localparam logic [6:0] op_auipc    = 7'b0010111;
    localparam logic [6:0] op_imm_32   = 7'b0011011;
    localparam logic [6:0] op_store    = 7'b0100011;
    localparam logic [6:0] op_store_fp = 7'b0100111;
    localparam logic [6:0] op_amo      = 7'b0101111;
    localparam logic [6:0] op_reg      = 7'b0110011;
    localparam logic [6:0] op_lui      = 7'b0110111;
    localparam logic [6:0] op_reg_32   = 7'b0111011;
    localparam logic [6:0] op_fmadd    = 7'b1000011;
    localparam logic [6:0] op_fmsub    = 7'b1000111;
    localparam logic [6:0] op_fnmsub   = 7'b1001011;
    localparam logic [6:0] op_fnmadd   = 7'b1001111;
    localparam logic [6:0] op_fp       = 7'b1010011;
    localparam logic [6:0] op_branch   = 7'b1100011;
    localparam logic [6:0] op_jalr     = 7'b1100111;
    localparam logic [6:0] op_jal      = 7'b1101111;
    localparam logic [6:0] op_system   = 7'b1110011;

    typedef struct packed {
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rs3_addr;
        logic [4:0] rd_addr;
        logic       irs1_v;
        logic       irs2_v;
        logic       frs1_v;
        logic       frs2_v;
        logic       frs3_v;
        logic       iwb_v;
        logic       fwb_v;
        logic       mem_v;
        logic       fence_v;
        logic       csr_w_v;
        logic       long_v;
    } bp_be_isd_predecode_s;

    function automatic logic is_fma(input logic [6:0] opcode);
        return (opcode == op_fmadd) || (opcode == op_fmsub)
            || (opcode == op_fnmsub) || (opcode == op_fnmadd);
    endfunction

endpackage

// File: rtl/bp_be_issue_queue_if.sv
// FE-to-queue and queue-to-detector signals; master drives the requests, slave is the queue.
interface bp_be_issue_queue_if
    import bp_be_issue_queue_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32
) ();

    logic                     fe_v_i;
    logic [vaddr_width_p-1:0] fe_pc_i;
    logic [instr_width_p-1:0] fe_instr_i;
    logic                     fe_ready_and_o;

    logic                     isd_v_o;
    logic [vaddr_width_p-1:0] isd_pc_o;
    logic [instr_width_p-1:0] isd_instr_o;
    bp_be_isd_predecode_s     isd_status_o;

    logic                     dispatch_v_i;
    logic                     commit_v_i;
    logic                     roll_i;
    logic                     clear_i;
    logic                     empty_o;

    modport master (
        output fe_v_i, fe_pc_i, fe_instr_i, dispatch_v_i, commit_v_i, roll_i, clear_i,
        input  fe_ready_and_o, isd_v_o, isd_pc_o, isd_instr_o, isd_status_o, empty_o
    );

    modport slave (
        input  fe_v_i, fe_pc_i, fe_instr_i, dispatch_v_i, commit_v_i, roll_i, clear_i,
        output fe_ready_and_o, isd_v_o, isd_pc_o, isd_instr_o, isd_status_o, empty_o
    );

endinterface

// File: rtl/bp_be_issue_queue_predecode.sv
// Combinational predecode of the head instruction: raw register fields plus
// register-file usage and hazard-class flags for the detector.
module bp_be_issue_predecode
    import bp_be_issue_queue_pkg::*;
(
    input  logic [31:0]          instr,
    output bp_be_isd_predecode_s status
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] funct5;
    logic       fp_from_int;
    logic       fp_to_int;
    logic       fp_two_src;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign funct5 = instr[31:27];

    // OP-FP subgroups: moves/converts from the integer file, results to the integer file,
    // and the arithmetic/sign-inject/min-max/compare forms that read a second FP source.
    assign fp_from_int = (funct5 == 5'b11010) || (funct5 == 5'b11110);
    assign fp_to_int   = (funct5 == 5'b11000) || (funct5 == 5'b11100) || (funct5 == 5'b10100);
    assign fp_two_src  = (funct5[4:3] == 2'b00) || (funct5 == 5'b10100);

    always_comb begin
        status          = '0;
        status.rs1_addr = instr[19:15];
        status.rs2_addr = instr[24:20];
        status.rs3_addr = instr[31:27];
        status.rd_addr  = instr[11:7];

        if (is_fma(opcode)) begin
            status.frs1_v = 1'b1;
            status.frs2_v = 1'b1;
            status.frs3_v = 1'b1;
            status.fwb_v  = 1'b1;
        end else begin
            case (opcode)
                op_imm, op_imm_32: begin
                    status.irs1_v = 1'b1;
                    status.iwb_v  = 1'b1;
                end
                op_reg, op_reg_32: begin
                    status.irs1_v = 1'b1;
                    status.irs2_v = 1'b1;
                    status.iwb_v  = 1'b1;
                    status.long_v = (funct7 == 7'b0000001) && funct3[2];
                end
                op_lui, op_auipc, op_jal: begin
                    status.iwb_v = 1'b1;
                end
                op_jalr: begin
                    status.irs1_v = 1'b1;
                    status.iwb_v  = 1'b1;
                end
                op_branch: begin
                    status.irs1_v = 1'b1;
                    status.irs2_v = 1'b1;
                end
                op_load: begin
                    status.irs1_v = 1'b1;
                    status.iwb_v  = 1'b1;
                    status.mem_v  = 1'b1;
                end
                op_store: begin
                    status.irs1_v = 1'b1;
                    status.irs2_v = 1'b1;
                    status.mem_v  = 1'b1;
                end
                op_amo: begin
                    status.irs1_v = 1'b1;
                    status.irs2_v = 1'b1;
                    status.iwb_v  = 1'b1;
                    status.mem_v  = 1'b1;
                end
                op_misc_mem: begin
                    status.fence_v = 1'b1;
                end
                op_system: begin
                    status.irs1_v  = (funct3 != 3'b000) && !funct3[2];
                    status.iwb_v   = (funct3 != 3'b000);
                    status.csr_w_v = (funct3 != 3'b000);
                end
                op_load_fp: begin
                    status.irs1_v = 1'b1;
                    status.fwb_v  = 1'b1;
                    status.mem_v  = 1'b1;
                end
                op_store_fp: begin
                    status.irs1_v = 1'b1;
                    status.frs2_v = 1'b1;
                    status.mem_v  = 1'b1;
                end
                op_fp: begin
                    status.irs1_v = fp_from_int;
                    status.frs1_v = !fp_from_int;
                    status.frs2_v = fp_two_src;
                    status.iwb_v  = fp_to_int;
                    status.fwb_v  = !fp_to_int;
                    status.long_v = (funct5 == 5'b01011) || (funct5 == 5'b00011);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bp_be_issue_queue.sv
// Issue queue between FE and the BE detector with commit/replay retention.
// Optional same-cycle FE-to-isd bypass is enabled by defining BP_BE_ISSUE_BYPASS_EN.
module bp_be_issue_queue
    import bp_be_issue_queue_pkg::*;
#(
    parameter int els_p         = 8,
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32
) (
    input logic               clk_i,
    input logic               reset_n_i,
    bp_be_issue_queue_if.slave io
);

    localparam int lg_els_lp    = $clog2(els_p);
    localparam int ptr_width_lp = lg_els_lp + 1;

    typedef logic [ptr_width_lp-1:0] ptr_t;

    ptr_t wptr, rptr, cptr;
    ptr_t wptr_n, rptr_n, cptr_n;

    logic [vaddr_width_p-1:0] pc_mem    [els_p];
    logic [instr_width_p-1:0] instr_mem [els_p];

    logic                     full;
    logic                     queued_v;
    logic                     bypass;
    logic                     isd_v;
    logic                     enq;
    logic                     deq;
    logic [vaddr_width_p-1:0] head_pc;
    logic [instr_width_p-1:0] head_instr;

    // Space is only reclaimed by commit, so fullness is measured against cptr, not rptr.
    assign full     = (wptr[lg_els_lp-1:0] == cptr[lg_els_lp-1:0])
                   && (wptr[lg_els_lp] != cptr[lg_els_lp]);
    assign queued_v = (rptr != wptr);

`ifdef BP_BE_ISSUE_BYPASS_EN
    assign bypass = !queued_v && io.fe_v_i && !full && !io.clear_i && !io.roll_i;
`else
    assign bypass = 1'b0;
`endif

    assign isd_v = queued_v || bypass;

    always_comb begin
        enq    = io.fe_v_i && !full && !io.clear_i;
        deq    = isd_v && io.dispatch_v_i && !io.roll_i;
        cptr_n = io.commit_v_i ? cptr + ptr_t'(1) : cptr;
        rptr_n = deq ? rptr + ptr_t'(1) : rptr;
        wptr_n = enq ? wptr + ptr_t'(1) : wptr;
        if (io.roll_i) begin
            rptr_n = cptr_n;
        end
        // A clear leaves only what has already been dispatched, including this cycle's dispatch.
        if (io.clear_i) begin
            wptr_n = rptr_n;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr <= '0;
            rptr <= '0;
            cptr <= '0;
        end else begin
            wptr <= wptr_n;
            rptr <= rptr_n;
            cptr <= cptr_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            pc_mem[wptr[lg_els_lp-1:0]]    <= io.fe_pc_i;
            instr_mem[wptr[lg_els_lp-1:0]] <= io.fe_instr_i;
        end
    end

    always_comb begin
        head_pc    = pc_mem[rptr[lg_els_lp-1:0]];
        head_instr = instr_mem[rptr[lg_els_lp-1:0]];
        if (bypass) begin
            head_pc    = io.fe_pc_i;
            head_instr = io.fe_instr_i;
        end
    end

    bp_be_issue_predecode predecode (
        .instr  (head_instr[31:0]),
        .status (io.isd_status_o)
    );

    assign io.fe_ready_and_o = !full;
    assign io.isd_v_o        = isd_v;
    assign io.isd_pc_o       = head_pc;
    assign io.isd_instr_o    = head_instr;
    assign io.empty_o        = (wptr == cptr);

    commit_without_dispatch: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) io.commit_v_i |-> (cptr != rptr)
    );

    pointer_order: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        (ptr_t'(wptr - cptr) <= ptr_t'(els_p)) && (ptr_t'(rptr - cptr) <= ptr_t'(wptr - cptr))
    );

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Self-checking bench for bp_be_issue_queue: vector table, directed replay/clear/predecode
// sequences and a randomized stream against a window-based reference model.
`timescale 1ns/1ps
module tb_bp_be_issue_queue;
    import bp_be_issue_queue_pkg::*;

    localparam int els = 8;
    localparam logic [31:0] addi   = 32'h00510093;
    localparam logic [31:0] fmadd  = 32'h203100C3;
`ifdef BP_BE_ISSUE_BYPASS_EN
    localparam bit byp_en = 1'b1;
`else
    localparam bit byp_en = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    bp_be_issue_queue_if #(.vaddr_width_p(39), .instr_width_p(32)) qif ();

    bp_be_issue_queue #(.els_p(els), .vaddr_width_p(39), .instr_width_p(32)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .io        (qif)
    );

    typedef struct {
        logic        fe_v;
        logic [38:0] pc;
        logic        disp;
        logic        com;
        logic        exp_ready;
        logic        exp_isd_v;
        logic        exp_empty;
        logic [38:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [10:0] flags;
    } pd_vec_t;

    typedef struct {
        logic [38:0] pc;
        logic [31:0] instr;
    } ent_t;

    vec_t    vecs[$];
    pd_vec_t pd_vecs[$];
    ent_t    win[$];
    int      issued;
    int      sent;
    int      cyc;
    logic    r_fe, r_disp, r_com, r_roll, r_clr, m_ready, m_head, m_byp, m_isd_v;
    logic [38:0] r_pc, m_pc;
    logic [31:0] r_instr, pd_instr, m_instr;
    logic [10:0] flag_mask;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic fe_v, input logic [38:0] pc, input logic [31:0] instr,
                                 input logic disp, input logic com, input logic roll, input logic clr);
        @(negedge clk);
        qif.fe_v_i       = fe_v;
        qif.fe_pc_i      = pc;
        qif.fe_instr_i   = instr;
        qif.dispatch_v_i = disp;
        qif.commit_v_i   = com;
        qif.roll_i       = roll;
        qif.clear_i      = clr;
        #1;
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        qif.fe_v_i = 1'b0; qif.dispatch_v_i = 1'b0; qif.commit_v_i = 1'b0;
        qif.roll_i = 1'b0; qif.clear_i = 1'b0;
        #1;
        checkOutput({tag, "_isd_v"}, 64'(qif.isd_v_o), 64'd0);
        checkOutput({tag, "_empty"}, 64'(qif.empty_o), 64'd1);
        checkOutput({tag, "_ready"}, 64'(qif.fe_ready_and_o), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic void addVec(input logic fe_v, input logic [38:0] pc, input logic disp,
                                   input logic com, input logic ready, input logic isd_v,
                                   input logic empty, input logic [38:0] exp_pc);
        vec_t v;
        v.fe_v = fe_v; v.pc = pc; v.disp = disp; v.com = com;
        v.exp_ready = ready; v.exp_isd_v = isd_v; v.exp_empty = empty; v.exp_pc = exp_pc;
        vecs.push_back(v);
    endfunction

    function automatic void addPd(input logic [31:0] instr, input logic [10:0] flags);
        pd_vec_t p;
        p.instr = instr; p.flags = flags;
        pd_vecs.push_back(p);
    endfunction

    function automatic logic [10:0] flagsOf(input bp_be_isd_predecode_s s);
        return {s.irs1_v, s.irs2_v, s.frs1_v, s.frs2_v, s.frs3_v, s.iwb_v, s.fwb_v,
                s.mem_v, s.fence_v, s.csr_w_v, s.long_v};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        qif.fe_v_i = 1'b0; qif.fe_pc_i = '0; qif.fe_instr_i = '0; qif.dispatch_v_i = 1'b0;
        qif.commit_v_i = 1'b0; qif.roll_i = 1'b0; qif.clear_i = 1'b0;

        // Fill to full, dispatch 3, commit 1, exactly one refill, then drain and commit all.
        for (int i = 0; i < 8; i++)
            addVec(1, 39'h1000 + 39'(4 * i), 0, 0, 1, (i != 0) || byp_en, (i == 0), 39'h1000);
        addVec(1, 39'h1020, 0, 0, 0, 1, 0, 39'h1000);
        for (int i = 0; i < 3; i++)
            addVec(0, 0, 1, 0, 0, 1, 0, 39'h1000 + 39'(4 * i));
        addVec(0, 0, 0, 1, 0, 1, 0, 39'h100c);
        addVec(1, 39'h2000, 0, 0, 1, 1, 0, 39'h100c);
        addVec(1, 39'h2004, 0, 0, 0, 1, 0, 39'h100c);
        for (int i = 0; i < 5; i++)
            addVec(0, 0, 1, 0, 0, 1, 0, 39'h100c + 39'(4 * i));
        addVec(0, 0, 1, 0, 0, 1, 0, 39'h2000);
        addVec(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            addVec(0, 0, 0, 1, (i != 0), 0, 0, 0);
        addVec(0, 0, 0, 0, 1, 0, 1, 0);

        // Flag order: irs1 irs2 frs1 frs2 frs3 iwb fwb mem fence csr_w long
        addPd(32'h00510093, 11'b10000100000);
        addPd(32'h005201B3, 11'b11000100000);
        addPd(32'h0063A423, 11'b11000001000);
        addPd(32'h203100C3, 11'b00111010000);
        addPd(32'h0FF0000F, 11'b00000000100);
        addPd(32'h023140B3, 11'b11000100001);
        addPd(32'h300110F3, 11'b10000100010);

        doReset("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].fe_v, vecs[i].pc, addi, vecs[i].disp, vecs[i].com, 0, 0);
            checkOutput($sformatf("vec%0d_ready", i), 64'(qif.fe_ready_and_o), 64'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d_isd_v", i), 64'(qif.isd_v_o), 64'(vecs[i].exp_isd_v));
            checkOutput($sformatf("vec%0d_empty", i), 64'(qif.empty_o), 64'(vecs[i].exp_empty));
            if (vecs[i].exp_isd_v)
                checkOutput($sformatf("vec%0d_pc", i), 64'(qif.isd_pc_o), 64'(vecs[i].exp_pc));
        end

        // Predecode of each head instruction; commit of the previous one overlaps the next enqueue.
        r_com = 1'b0;
        for (int i = 0; i < pd_vecs.size(); i++) begin
            pd_instr = pd_vecs[i].instr;
            applyStimulus(1, 39'h3000 + 39'(4 * i), pd_instr, 0, r_com, 0, 0);
            applyStimulus(0, 0, 0, 1, 0, 0, 0);
            checkOutput($sformatf("pd%0d_isd_v", i), 64'(qif.isd_v_o), 64'd1);
            checkOutput($sformatf("pd%0d_instr", i), 64'(qif.isd_instr_o), 64'(pd_instr));
            checkOutput($sformatf("pd%0d_flags", i), 64'(flagsOf(qif.isd_status_o)), 64'(pd_vecs[i].flags));
            checkOutput($sformatf("pd%0d_addrs", i),
                        64'({qif.isd_status_o.rs1_addr, qif.isd_status_o.rs2_addr,
                             qif.isd_status_o.rs3_addr, qif.isd_status_o.rd_addr}),
                        64'({pd_instr[19:15], pd_instr[24:20], pd_instr[31:27], pd_instr[11:7]}));
            r_com = 1'b1;
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("pd_end_empty", 64'(qif.empty_o), 64'd1);

        // Replay: dispatch 0x100..0x10c, commit two, roll back to 0x108.
        doReset("roll_reset");
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 39'h100 + 39'(4 * i), addi, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 0);
            checkOutput($sformatf("roll_disp%0d_pc", i), 64'(qif.isd_pc_o), 64'(39'h100 + 39'(4 * i)));
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 0);
            checkOutput($sformatf("roll_reissue%0d_v", i), 64'(qif.isd_v_o), 64'd1);
            checkOutput($sformatf("roll_reissue%0d_pc", i), 64'(qif.isd_pc_o), 64'(39'h108 + 39'(4 * i)));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("roll_drained_isd_v", 64'(qif.isd_v_o), 64'd0);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("roll_end_empty", 64'(qif.empty_o), 64'd1);

        // Clear with 2 dispatched and 5 undispatched entries while FE offers one more.
        doReset("clear_reset");
        for (int i = 0; i < 7; i++)
            applyStimulus(1, 39'h200 + 39'(4 * i), addi, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 39'h300, addi, 0, 0, 0, 1);
        checkOutput("clear_pre_pc", 64'(qif.isd_pc_o), 64'(39'h208));
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("clear_isd_v", 64'(qif.isd_v_o), 64'd0);
        checkOutput("clear_empty0", 64'(qif.empty_o), 64'd0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("clear_empty1", 64'(qif.empty_o), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("clear_empty2", 64'(qif.empty_o), 64'd1);
        checkOutput("clear_dropped", 64'(qif.isd_v_o), 64'd0);

`ifdef BP_BE_ISSUE_BYPASS_EN
        // Same-cycle presentation on an empty queue, then a bypassed dispatch that stays replayable.
        applyStimulus(1, 39'h500, fmadd, 0, 0, 0, 0);
        flag_mask = 11'b00111010000;
        checkOutput("byp_isd_v", 64'(qif.isd_v_o), 64'd1);
        checkOutput("byp_pc", 64'(qif.isd_pc_o), 64'(39'h500));
        checkOutput("byp_fp_flags", 64'(flagsOf(qif.isd_status_o) & flag_mask), 64'(flag_mask));
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("byp_held_pc", 64'(qif.isd_pc_o), 64'(39'h500));
        applyStimulus(1, 39'h504, addi, 1, 1, 0, 0);
        checkOutput("byp2_isd_v", 64'(qif.isd_v_o), 64'd1);
        checkOutput("byp2_pc", 64'(qif.isd_pc_o), 64'(39'h504));
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("byp2_after_isd_v", 64'(qif.isd_v_o), 64'd0);
        checkOutput("byp2_resident", 64'(qif.empty_o), 64'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("byp2_replay_pc", 64'(qif.isd_pc_o), 64'(39'h504));
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
`endif

        // Reset with entries in flight must empty the queue without waiting for a clock.
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 39'h600 + 39'(4 * i), addi, 0, 0, 0, 0);
        doReset("midreset");

        // Random stream of 40 instructions against a window model: win holds cptr..wptr,
        // issued counts how many of those have been dispatched.
        win.delete();
        issued = 0;
        sent = 0;
        cyc = 0;
        while (!(sent == 40 && win.size() == 0) && cyc < 3000) begin
            r_fe    = (sent < 40) && ($urandom_range(3) != 0);
            r_pc    = 39'h4000 + 39'(4 * sent);
            r_instr = $urandom;
            r_disp  = $urandom_range(1) == 1;
            r_com   = (issued > 0) && ($urandom_range(2) == 0);
            r_roll  = $urandom_range(15) == 0;
            r_clr   = $urandom_range(39) == 0;

            m_ready = win.size() < els;
            m_head  = issued < win.size();
            m_byp   = byp_en && !m_head && r_fe && m_ready && !r_roll && !r_clr;
            m_isd_v = m_head || m_byp;
            m_pc    = m_head ? win[issued].pc : r_pc;
            m_instr = m_head ? win[issued].instr : r_instr;

            applyStimulus(r_fe, r_pc, r_instr, r_disp, r_com, r_roll, r_clr);
            checkOutput($sformatf("rnd%0d_ready", cyc), 64'(qif.fe_ready_and_o), 64'(m_ready));
            checkOutput($sformatf("rnd%0d_isd_v", cyc), 64'(qif.isd_v_o), 64'(m_isd_v));
            checkOutput($sformatf("rnd%0d_empty", cyc), 64'(qif.empty_o), 64'(win.size() == 0));
            if (m_isd_v) begin
                checkOutput($sformatf("rnd%0d_pc", cyc), 64'(qif.isd_pc_o), 64'(m_pc));
                checkOutput($sformatf("rnd%0d_instr", cyc), 64'(qif.isd_instr_o), 64'(m_instr));
            end

            if (r_com) begin
                void'(win.pop_front());
                issued--;
            end
            if (m_isd_v && r_disp && !r_roll)
                issued++;
            if (r_roll)
                issued = 0;
            if (r_clr) begin
                while (win.size() > issued)
                    void'(win.pop_back());
            end
            if (r_fe && m_ready && !r_clr) begin
                win.push_back('{pc: r_pc, instr: r_instr});
                sent++;
            end
            cyc++;
        end
        checkOutput("rnd_completed", 64'(sent == 40 && win.size() == 0), 64'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("rnd_end_empty", 64'(qif.empty_o), 64'd1);
        checkOutput("rnd_end_ready", 64'(qif.fe_ready_and_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
